stage2_decode: RTL and testbench
================================

// Module: stage2_decode
// PURPOSE
//  Inverse of the stage-2 check-bit appender. Accepts a 17-bit word {data[15:0], chk},
//  recomputes the expected check bit from data under key_bits[1:0], and strips it.
//  Presents data[15:0] downstream with a per-word error flag and a saturating error count.
//  Sits at the receive side of the stage-2 link, feeding the inverse of stage 1.
// PARAMETERS
//  ERR_CNT_W  8  width of err_count; count saturates at 2**ERR_CNT_W-1
// PORTS
//  clk2       in   1          single clock, rising edge
//  rst        in   1          asynchronous, active-high reset
//  key_bits   in   5          key; only [1:0] used, sampled on word accept
//  stg2_in    in   17         [16:1] data, [0] received check bit
//  stg2_valid in   1          upstream word valid
//  stg2_ready out  1          decoder can accept (high only in IDLE)
//  dec_out    out  16         recovered data
//  dec_valid  out  1          dec_out/chk_err valid; held until dec_ready
//  dec_ready  in   1          downstream accepts
//  chk_err    out  1          check-bit mismatch for the word on dec_out
//  err_count  out  ERR_CNT_W  number of mismatched words since reset, saturating
// BEHAVIOUR
//  - Reset (async, immediate): state=IDLE, stg2_ready=0 until first edge after release,
//    dec_out=0, dec_valid=0, chk_err=0, err_count=0, internal latches=0.
//  - FSM: IDLE -> CHECK -> EMIT -> IDLE.
//    IDLE : stg2_ready=1. On stg2_valid=1 at edge: latch stg2_in and key_bits[1:0], go CHECK.
//    CHECK: stg2_ready=0. One cycle: compute expected bit, compare with latched bit[0].
//           At edge: load dec_out=latched[16:1], chk_err=mismatch, go EMIT, dec_valid=1.
//    EMIT : dec_valid=1, outputs frozen. On dec_ready=1 at edge: dec_valid=0, go IDLE.
//  - Expected check bit on latched data d[15:0] by latched key k:
//    k=00: ~^d    k=01: |d    k=10: &d    k=11: |d
//  - Latency: word accepted at edge N -> dec_valid high after edge N+1. Min throughput:
//    one word per 3 cycles (dec_ready held high).
//  - key_bits changes after accept do not affect the word in flight.
//  - err_count increments by 1 at the CHECK->EMIT edge when mismatch; holds at
//    all-ones (no wrap).
//  - stg2_valid while not IDLE is ignored (upstream must hold the word; no loss of a
//    held word).
//  - dec_ready while not EMIT is ignored. dec_valid never drops without dec_ready.
//  - rst asserted in any state aborts the word in flight; no partial output survives.
// CONFIGURATION
//  STG2_DEC_DROP_EN defined: a mismatched word is discarded. CHECK -> IDLE directly,
//    dec_valid stays 0, dec_out/chk_err keep previous values, err_count still increments.
//  STG2_DEC_DROP_EN undefined: every word is emitted; chk_err=1 marks a mismatch.
// TESTING
//  1 key=00, stg2_in=17'h00001 -> dec_out=16'h0000, chk_err=0, dec_valid after 2 edges.
//  2 key=10, 17'h1FFFF then 17'h1FFFE -> dec_out=16'hFFFF both, chk_err 0 then 1,
//    err_count=1 (DROP_EN: 2nd word not emitted, err_count=1).
//  3 key=11, 17'h10001 -> dec_out=16'h8000, chk_err=0; key=01, 17'h00001 -> chk_err=1.
//  4 dec_ready=0 for 5 cycles in EMIT, change key and stg2_in -> outputs stable,
//    stg2_ready=0, single word delivered on dec_ready=1.
//  5 ERR_CNT_W=2, five bad words -> err_count 1,2,3,3,3 (no wrap).
//  6 rst pulsed in CHECK and in EMIT -> all outputs 0 at once, next word decodes normally.

Source files
------------

// File: rtl/stage2_decode.sv
// Stage-2 receive decoder: checks and strips the appended check bit, flags and counts mismatches.
// Build option: define STG2_DEC_DROP_EN to discard mismatched words instead of emitting them.
module stage2_decode #(
  parameter int ERR_CNT_W = 8
) (
  input  logic                 clk2,
  input  logic                 rst,
  input  logic [4:0]           key_bits,
  input  logic [16:0]          stg2_in,
  input  logic                 stg2_valid,
  output logic                 stg2_ready,
  output logic [15:0]          dec_out,
  output logic                 dec_valid,
  input  logic                 dec_ready,
  output logic                 chk_err,
  output logic [ERR_CNT_W-1:0] err_count
);

  // state | meaning
  // IDLE  | waiting for an upstream word
  // CHECK | latched word being checked
  // EMIT  | decoded word presented, waiting for dec_ready
  typedef enum logic [1:0] {IDLE, CHECK, EMIT} state_t;

  state_t               state_q, state_d;
  logic                 ready_q, ready_d;
  logic [16:0]          word_q, word_d;
  logic [1:0]           key_q, key_d;
  logic [15:0]          dout_q, dout_d;
  logic                 dvalid_q, dvalid_d;
  logic                 cerr_q, cerr_d;
  logic [ERR_CNT_W-1:0] cnt_q, cnt_d;
  logic                 exp_bit;
  logic                 mismatch;
  logic                 unused_key;

  assign unused_key = ^key_bits[4:2];

  always_comb begin
    exp_bit = 1'b0;
    case (key_q)
      2'b00:   exp_bit = ~^word_q[16:1];
      2'b01:   exp_bit = |word_q[16:1];
      2'b10:   exp_bit = &word_q[16:1];
      default: exp_bit = |word_q[16:1];
    endcase
    mismatch = exp_bit ^ word_q[0];
  end

  always_comb begin
    state_d  = state_q;
    word_d   = word_q;
    key_d    = key_q;
    dout_d   = dout_q;
    dvalid_d = dvalid_q;
    cerr_d   = cerr_q;
    cnt_d    = cnt_q;
    case (state_q)
      IDLE: begin
        // ready_q gates acceptance so no word is taken on the first edge after reset
        if (ready_q && stg2_valid) begin
          word_d  = stg2_in;
          key_d   = key_bits[1:0];
          state_d = CHECK;
        end
      end
      CHECK: begin
        if (mismatch && (cnt_q != {ERR_CNT_W{1'b1}}))
          cnt_d = cnt_q + ERR_CNT_W'(1);
`ifdef STG2_DEC_DROP_EN
        if (mismatch) begin
          state_d = IDLE;
        end else begin
          dout_d   = word_q[16:1];
          cerr_d   = 1'b0;
          dvalid_d = 1'b1;
          state_d  = EMIT;
        end
`else
        dout_d   = word_q[16:1];
        cerr_d   = mismatch;
        dvalid_d = 1'b1;
        state_d  = EMIT;
`endif
      end
      EMIT: begin
        if (dec_ready) begin
          dvalid_d = 1'b0;
          state_d  = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    ready_d = (state_d == IDLE);
  end

  always_ff @(posedge clk2 or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      ready_q  <= 1'b0;
      word_q   <= '0;
      key_q    <= '0;
      dout_q   <= '0;
      dvalid_q <= 1'b0;
      cerr_q   <= 1'b0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      ready_q  <= ready_d;
      word_q   <= word_d;
      key_q    <= key_d;
      dout_q   <= dout_d;
      dvalid_q <= dvalid_d;
      cerr_q   <= cerr_d;
      cnt_q    <= cnt_d;
    end
  end

  assign stg2_ready = ready_q;
  assign dec_out    = dout_q;
  assign dec_valid  = dvalid_q;
  assign chk_err    = cerr_q;
  assign err_count  = cnt_q;

endmodule

// File: tb/tb_stage2_decode.sv
// Scoreboard bench for stage2_decode: default-width instance plus a 2-bit error-counter instance.
module tb_stage2_decode;

  logic        clk = 1'b0;
  logic        rst;
  logic [4:0]  key_bits;
  logic [16:0] stg2_in;
  logic        stg2_valid;
  logic        dec_ready;

  logic        stg2_ready, dec_valid, chk_err;
  logic [15:0] dec_out;
  logic [7:0]  err_count;
  logic        stg2_ready2, dec_valid2, chk_err2;
  logic [15:0] dec_out2;
  logic [1:0]  err_count2;

  typedef struct {
    logic [15:0] d;
    logic        e;
    logic [7:0]  c8;
    logic [1:0]  c2;
  } exp_t;

  exp_t q[$];
  int   n_cmp = 0;
  int   n_bad = 0;
  int   m8 = 0;
  int   m2 = 0;

  stage2_decode #(.ERR_CNT_W(8)) u_dut (
    .clk2(clk), .rst(rst), .key_bits(key_bits), .stg2_in(stg2_in),
    .stg2_valid(stg2_valid), .stg2_ready(stg2_ready), .dec_out(dec_out),
    .dec_valid(dec_valid), .dec_ready(dec_ready), .chk_err(chk_err),
    .err_count(err_count));

  stage2_decode #(.ERR_CNT_W(2)) u_dut2 (
    .clk2(clk), .rst(rst), .key_bits(key_bits), .stg2_in(stg2_in),
    .stg2_valid(stg2_valid), .stg2_ready(stg2_ready2), .dec_out(dec_out2),
    .dec_valid(dec_valid2), .dec_ready(dec_ready), .chk_err(chk_err2),
    .err_count(err_count2));

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (!rst && dec_valid && dec_ready) begin
      if (q.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL unexpected_word: got %0h expected none", dec_out);
      end else begin
        exp_t e;
        e = q.pop_front();
        check("dec_out", dec_out, e.d);
        check("chk_err", chk_err, e.e);
        check("err_count", err_count, e.c8);
        check("dec_out_w2", dec_out2, e.d);
        check("err_count_w2", err_count2, e.c2);
      end
    end
  end

  task automatic send(input logic [1:0] k, input logic [16:0] w, input logic [15:0] ed,
                      input logic ee, input bit push);
    int   n;
    logic r;
    key_bits   = {3'b110, k};
    stg2_in    = w;
    stg2_valid = 1'b1;
    n = 0;
    r = 1'b0;
    while (!r && n < 40) begin
      @(negedge clk);
      r = stg2_ready;
      @(posedge clk);
      n++;
    end
    #1;
    stg2_valid = 1'b0;
    key_bits   = ~key_bits;
    stg2_in    = ~w;
    if (!r) begin
      check("accept_timeout", 32'd0, 32'd1);
      return;
    end
    if (ee) begin
      if (m8 < 255) m8++;
      if (m2 < 3) m2++;
    end
`ifdef STG2_DEC_DROP_EN
    if (push && !ee) q.push_back('{ed, ee, m8[7:0], m2[1:0]});
`else
    if (push) q.push_back('{ed, ee, m8[7:0], m2[1:0]});
`endif
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (q.size() != 0 && n < 40) begin
      @(posedge clk);
      n++;
    end
    #1;
    check("drain", q.size(), 0);
    repeat (2) @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    #1;
    check("rst_dec_valid", dec_valid, 0);
    check("rst_dec_out", dec_out, 0);
    check("rst_chk_err", chk_err, 0);
    check("rst_err_count", err_count, 0);
    check("rst_err_count_w2", err_count2, 0);
    check("rst_stg2_ready", stg2_ready, 0);
    m8 = 0;
    m2 = 0;
    q.delete();
    @(posedge clk);
    #1;
    rst = 1'b0;
    #1;
    check("ready_after_release", stg2_ready, 0);
    @(posedge clk);
    #1;
    check("ready_first_edge", stg2_ready, 1);
  endtask

  initial begin
    int n;
    rst        = 1'b0;
    key_bits   = '0;
    stg2_in    = '0;
    stg2_valid = 1'b0;
    dec_ready  = 1'b1;
    #1;
    do_reset();

    // key 00, parity-style check; latency
    send(2'b00, 17'h00001, 16'h0000, 1'b0, 1'b1);
    check("t1_not_yet_valid", dec_valid, 0);
    @(posedge clk);
    #1;
    check("t1_valid_after_2", dec_valid, 1);
    drain();

    // key 10, all-ones good then bad
    send(2'b10, 17'h1FFFF, 16'hFFFF, 1'b0, 1'b1);
    send(2'b10, 17'h1FFFE, 16'hFFFF, 1'b1, 1'b1);
    drain();
    check("t2_err_count", err_count, m8);

    // keys 11 / 01 / 00 extra patterns
    send(2'b11, 17'h10001, 16'h8000, 1'b0, 1'b1);
    send(2'b01, 17'h00001, 16'h0000, 1'b1, 1'b1);
    send(2'b01, 17'h00003, 16'h0001, 1'b0, 1'b1);
    send(2'b00, 17'h00000, 16'h0000, 1'b1, 1'b1);
    send(2'b00, 17'h00006, 16'h0003, 1'b1, 1'b1);
    drain();

    // stall in EMIT with inputs churning
    dec_ready = 1'b0;
    send(2'b01, 17'h12345, 16'h91A2, 1'b0, 1'b1);
    n = 0;
    while (!dec_valid && n < 10) begin
      @(posedge clk);
      #1;
      n++;
    end
    check("t4_reached_emit", dec_valid, 1);
    for (int i = 0; i < 5; i++) begin
      stg2_valid = 1'b1;
      stg2_in    = 17'($urandom);
      key_bits   = 5'($urandom);
      @(posedge clk);
      #1;
      check("t4_hold_valid", dec_valid, 1);
      check("t4_hold_out", dec_out, 16'h91A2);
      check("t4_hold_err", chk_err, 0);
      check("t4_ready_low", stg2_ready, 0);
    end
    stg2_valid = 1'b0;
    dec_ready  = 1'b1;
    drain();
    check("t4_single_word", dec_valid, 0);

    // saturation of the narrow counter
    do_reset();
    for (int i = 0; i < 5; i++) send(2'b01, 17'h00001, 16'h0000, 1'b1, 1'b1);
    drain();
    check("t5_sat_w2", err_count2, 3);
    check("t5_count_w8", err_count, 5);

    // reset while in CHECK
    send(2'b10, 17'h1FFFE, 16'hFFFF, 1'b1, 1'b0);
    do_reset();
    // reset while in EMIT
    dec_ready = 1'b0;
    send(2'b10, 17'h1FFFF, 16'hFFFF, 1'b0, 1'b0);
    @(posedge clk);
    #1;
    check("t6_in_emit", dec_valid, 1);
    check("t6_emit_out", dec_out, 16'hFFFF);
    do_reset();
    dec_ready = 1'b1;
    send(2'b00, 17'h00001, 16'h0000, 1'b0, 1'b1);
    send(2'b10, 17'h1FFFE, 16'hFFFF, 1'b1, 1'b1);
    drain();
    check("t6_err_count", err_count, m8);

    repeat (3) @(posedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
